// File: rtl/cr_osf_ob_out_pkg.sv
// ----------------------------------------------------------------------------
// cr_osf_ob_out_pkg
//   Shared types for the OSF outbound egress stage.
//   - axi4s_dp_bus_t   : AXI4-Stream data-path beat (tvalid travels inside)
//   - osf_ob_out_st_e  : egress frame-tracking states
//   - OSF_OB_BUF_DEPTH : number of entries in the egress re-timing buffer
// ----------------------------------------------------------------------------
package cr_osf_ob_out_pkg;

    typedef struct packed {
        logic        tvalid;
        logic [63:0] tdata;
        logic [7:0]  tuser;   // [0] = start of transfer, [1] = end of transfer
        logic [7:0]  tstrb;
        logic [0:0]  tid;
        logic        tlast;
    } axi4s_dp_bus_t;

    typedef enum logic [1:0] {
        OB_IDLE,
        OB_FRAME,
        OB_FROZEN
    } osf_ob_out_st_e;

    localparam int unsigned OSF_OB_BUF_DEPTH = 2;

endpackage

// File: rtl/cr_osf_ob_out_skid.sv
// ----------------------------------------------------------------------------
// cr_osf_ob_skid
//   Two-entry in-order re-timing buffer for the OSF egress stage.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     push        : write push_data at the tail (caller guarantees count < 2)
//     push_data   : beat to store
//     pop         : retire the head entry (caller guarantees count != 0)
//     count       : number of valid entries (0..2)
//     head        : oldest entry; held stable while not popped
// ----------------------------------------------------------------------------
module cr_osf_ob_skid
    import cr_osf_ob_out_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  axi4s_dp_bus_t push_data,
    input  logic          pop,
    output logic [1:0]    count,
    output axi4s_dp_bus_t head
);

    axi4s_dp_bus_t entry0;  // head
    axi4s_dp_bus_t entry1;  // second entry, only meaningful when count == 2

    assign head = entry0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                // Retiring head: the older tail (if any) moves up, otherwise a
                // concurrent push lands directly in the head slot.
                if (count == 2'd2) begin
                    entry0 <= entry1;
                end else if (push) begin
                    entry0 <= push_data;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    entry0 <= push_data;
                end else begin
                    entry1 <= push_data;
                end
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/cr_osf_ob_out.sv
// ----------------------------------------------------------------------------
// cr_osf_ob_out
//   OSF output egress stage. Pops the merged first-word-fall-through outbound
//   FIFO into a 2-entry buffer and drives it as an AXI4-Stream master. Tracks
//   frame boundaries, honours a debug freeze-at-frame-boundary request, counts
//   delivered beats/frames and (optionally) flags framing errors.
//
//   Build option: CR_OSF_OB_PROT_CHK_EN enables the framing-error pulses;
//   without it err_no_sot / err_sot_in_frame are tied low.
//
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     ob_fifo_rdata     : head of outbound FIFO (valid when !ob_fifo_empty)
//     ob_fifo_empty     : outbound FIFO empty
//     ob_fifo_rd        : FIFO pop strobe (combinational, ready-independent)
//     osf_ob_out        : stream to next engine (tvalid inside the struct)
//     osf_ob_in_ready   : downstream tready
//     freeze_req        : stop at the next frame boundary
//     freeze_ack        : frozen and buffer empty
//     frame_cnt         : EOT beats accepted downstream (wraps)
//     beat_cnt          : beats accepted downstream (wraps)
//     err_no_sot        : pulse, beat popped outside a frame without SOT
//     err_sot_in_frame  : pulse, SOT popped inside a frame, or tlast/EOT
//                         disagreement on a retired beat
// ----------------------------------------------------------------------------
module cr_osf_ob_out
    import cr_osf_ob_out_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  axi4s_dp_bus_t    ob_fifo_rdata,
    input  logic             ob_fifo_empty,
    output logic             ob_fifo_rd,
    output axi4s_dp_bus_t    osf_ob_out,
    input  logic             osf_ob_in_ready,
    input  logic             freeze_req,
    output logic             freeze_ack,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             err_no_sot,
    output logic             err_sot_in_frame
);

    if (BUF_DEPTH != OSF_OB_BUF_DEPTH) begin : g_bad_depth
        $error("cr_osf_ob_out: BUF_DEPTH must be 2");
    end

    osf_ob_out_st_e state;
    osf_ob_out_st_e state_nxt;
    logic           pop_en;
    logic [1:0]     buf_cnt;
    axi4s_dp_bus_t  buf_head;
    logic           retire;

    cr_osf_ob_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ob_fifo_rd),
        .push_data (ob_fifo_rdata),
        .pop       (retire),
        .count     (buf_cnt),
        .head      (buf_head)
    );

    always_comb begin
        osf_ob_out        = buf_head;
        osf_ob_out.tvalid = (buf_cnt != 2'd0);
    end

    assign retire     = osf_ob_out.tvalid && osf_ob_in_ready;
    assign freeze_ack = (state == OB_FROZEN) && (buf_cnt == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        pop_en    = 1'b0;
        state_nxt = state;
        case (state)
            OB_IDLE:   pop_en = !freeze_req;
            OB_FRAME:  pop_en = 1'b1;
            OB_FROZEN: pop_en = 1'b0;
            default:   pop_en = 1'b0;
        endcase

        ob_fifo_rd = !ob_fifo_empty && (buf_cnt < 2'd2) && pop_en;

        case (state)
            OB_IDLE: begin
                // pop_en is low whenever freeze_req is high, so a freeze here
                // never coincides with a pop.
                if (freeze_req) begin
                    state_nxt = OB_FROZEN;
                end else if (ob_fifo_rd) begin
                    state_nxt = ob_fifo_rdata.tuser[1] ? OB_IDLE : OB_FRAME;
                end
            end
            OB_FRAME: begin
                if (ob_fifo_rd && ob_fifo_rdata.tuser[1]) begin
                    state_nxt = freeze_req ? OB_FROZEN : OB_IDLE;
                end
            end
            OB_FROZEN: begin
                if (!freeze_req) begin
                    state_nxt = OB_IDLE;
                end
            end
            default: state_nxt = OB_IDLE;
        endcase
    end

    // Counters are written every cycle (increment of 0 or 1) so the register
    // always reloads from its own current value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            beat_cnt  <= beat_cnt  + CNT_W'(retire);
            frame_cnt <= frame_cnt + CNT_W'(retire && buf_head.tuser[1]);
        end
    end

`ifdef CR_OSF_OB_PROT_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_no_sot       <= 1'b0;
            err_sot_in_frame <= 1'b0;
        end else begin
            err_no_sot       <= ob_fifo_rd && (state == OB_IDLE) &&
                                !ob_fifo_rdata.tuser[0];
            err_sot_in_frame <= (ob_fifo_rd && (state == OB_FRAME) &&
                                 ob_fifo_rdata.tuser[0]) ||
                                (retire && (buf_head.tlast != buf_head.tuser[1]));
        end
    end
`else
    assign err_no_sot       = 1'b0;
    assign err_sot_in_frame = 1'b0;
`endif

endmodule

// File: tb/tb_cr_osf_ob_out.sv
// ----------------------------------------------------------------------------
// tb_cr_osf_ob_out
//   Self-checking bench for cr_osf_ob_out. A queue-based behavioural model of
//   the FIFO, buffer, frame tracking, counters and error pulses is compared
//   against the DUT on every falling edge; directed scenarios add literal
//   expectations at key points.
// ----------------------------------------------------------------------------
module tb_cr_osf_ob_out;
    import cr_osf_ob_out_pkg::*;

`ifdef CR_OSF_OB_PROT_CHK_EN
    localparam int unsigned ERR_EN = 1;
`else
    localparam int unsigned ERR_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    axi4s_dp_bus_t fifo_head;
    logic          fifo_empty;
    logic          ob_fifo_rd;
    axi4s_dp_bus_t osf_ob_out;
    logic          ready;
    logic          freeze_req;
    logic          freeze_ack;
    logic [31:0]   frame_cnt;
    logic [31:0]   beat_cnt;
    logic          err_no_sot;
    logic          err_sot_in_frame;

    always #5 clk = ~clk;

    cr_osf_ob_out #(.CNT_W(32), .BUF_DEPTH(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ob_fifo_rdata    (fifo_head),
        .ob_fifo_empty    (fifo_empty),
        .ob_fifo_rd       (ob_fifo_rd),
        .osf_ob_out       (osf_ob_out),
        .osf_ob_in_ready  (ready),
        .freeze_req       (freeze_req),
        .freeze_ack       (freeze_ack),
        .frame_cnt        (frame_cnt),
        .beat_cnt         (beat_cnt),
        .err_no_sot       (err_no_sot),
        .err_sot_in_frame (err_sot_in_frame)
    );

    int unsigned cmp_n = 0;
    int unsigned err_n = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    axi4s_dp_bus_t src[$];     // upstream FIFO contents
    axi4s_dp_bus_t mq[$];      // beats held by the egress stage
    bit            m_frame;    // inside a frame
    bit            m_frozen;   // stopped at a frame boundary
    logic [31:0]   m_beats;
    logic [31:0]   m_frames;
    bit            m_e_no;
    bit            m_e_sif;
    int unsigned   seq = 0;
    int unsigned   seen_no = 0;
    int unsigned   seen_sif = 0;

    // decisions sampled at the falling edge, applied after the rising edge
    bit            s_pop, s_ret, s_frz;
    axi4s_dp_bus_t s_head;

    function automatic axi4s_dp_bus_t mk(input logic [7:0] tu, input int unsigned idx);
        axi4s_dp_bus_t b;
        b        = '0;
        b.tdata  = {32'hC0DE_0000, idx};
        b.tuser  = tu;
        b.tstrb  = 8'hFF;
        b.tid    = idx[0];
        b.tlast  = tu[1];
        return b;
    endfunction

    task automatic refresh();
        fifo_empty = (src.size() == 0);
        fifo_head  = fifo_empty ? '0 : src[0];
    endtask

    task automatic push(input logic [7:0] tu);
        src.push_back(mk(tu, seq));
        seq++;
        refresh();
    endtask

    task automatic model_reset();
        src.delete();
        mq.delete();
        m_frame  = 0;
        m_frozen = 0;
        m_beats  = '0;
        m_frames = '0;
        m_e_no   = 0;
        m_e_sif  = 0;
        refresh();
    endtask

    // compare process
    always @(negedge clk) begin
        bit pen;
        axi4s_dp_bus_t exp_b;
        if (!rst_n) begin
            s_pop = 0;
            s_ret = 0;
        end else begin
            pen    = m_frozen ? 1'b0 : (m_frame ? 1'b1 : !freeze_req);
            s_pop  = !fifo_empty && (mq.size() < 2) && pen;
            s_ret  = (mq.size() != 0) && ready;
            s_frz  = freeze_req;
            s_head = fifo_head;
        end
        chk("tvalid", 128'(osf_ob_out.tvalid), 128'(mq.size() != 0));
        if (mq.size() != 0) begin
            exp_b        = mq[0];
            exp_b.tvalid = 1'b1;
            chk("beat", 128'(osf_ob_out), 128'(exp_b));
        end
        chk("fifo_rd",    128'(ob_fifo_rd),       128'(s_pop));
        chk("freeze_ack", 128'(freeze_ack),       128'(m_frozen && mq.size() == 0));
        chk("beat_cnt",   128'(beat_cnt),         128'(m_beats));
        chk("frame_cnt",  128'(frame_cnt),        128'(m_frames));
        chk("err_no_sot", 128'(err_no_sot),       128'(m_e_no));
        chk("err_sif",    128'(err_sot_in_frame), 128'(m_e_sif));
        if (err_no_sot)       seen_no++;
        if (err_sot_in_frame) seen_sif++;
    end

    // model update, just after each rising edge
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            m_e_no  = 0;
            m_e_sif = 0;
            if (ERR_EN != 0) begin
                m_e_no  = s_pop && !m_frame && !m_frozen && !s_head.tuser[0];
                m_e_sif = (s_pop && m_frame && s_head.tuser[0]) ||
                          (s_ret && (mq[0].tlast != mq[0].tuser[1]));
            end
            if (s_ret) begin
                m_beats = m_beats + 1;
                if (mq[0].tuser[1]) m_frames = m_frames + 1;
                void'(mq.pop_front());
            end
            if (s_pop) begin
                mq.push_back(s_head);
                void'(src.pop_front());
            end
            if (m_frozen) begin
                if (!s_frz) m_frozen = 0;
            end else if (!m_frame) begin
                if (s_frz) m_frozen = 1;
                else if (s_pop) m_frame = !s_head.tuser[1];
            end else if (s_pop && s_head.tuser[1]) begin
                m_frame  = 0;
                m_frozen = s_frz;
            end
            refresh();
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain(input int unsigned max);
        bit done = 0;
        for (int unsigned i = 0; i < max; i++) begin
            if (src.size() == 0 && mq.size() == 0) begin
                done = 1;
                break;
            end
            step(1);
        end
        chk("drain_done", 128'(done), 128'(1));
    endtask

    initial begin
        rst_n      = 1'b0;
        ready      = 1'b0;
        freeze_req = 1'b0;
        model_reset();
        step(3);
        chk("rst_tvalid", 128'(osf_ob_out), 128'(0));
        chk("rst_rd",     128'(ob_fifo_rd), 128'(0));
        rst_n = 1'b1;
        step(1);

        // 1: 4-beat frame, ready held high
        ready = 1'b1;
        push(8'h01); push(8'h00); push(8'h00); push(8'h02);
        step(1);
        chk("t1_first_valid", 128'(osf_ob_out.tvalid), 128'(1));
        chk("t1_first_tuser", 128'(osf_ob_out.tuser),  128'(8'h01));
        drain(20);
        step(2);
        chk("t1_frames", 128'(frame_cnt), 128'(1));
        chk("t1_beats",  128'(beat_cnt),  128'(4));

        // 2: same frame with downstream stalled
        ready = 1'b0;
        push(8'h01); push(8'h00); push(8'h00); push(8'h02);
        step(4);
        chk("t2_full_rd",    128'(ob_fifo_rd),        128'(0));
        chk("t2_stall_vld",  128'(osf_ob_out.tvalid), 128'(1));
        chk("t2_stall_head", 128'(osf_ob_out.tuser),  128'(8'h01));
        chk("t2_src_left",   128'(src.size()),        128'(2));
        ready = 1'b1;
        drain(20);
        step(2);
        chk("t2_frames", 128'(frame_cnt), 128'(2));
        chk("t2_beats",  128'(beat_cnt),  128'(8));

        // 3: freeze requested mid-frame stops after the EOT beat
        push(8'h01); push(8'h00);
        step(3);
        freeze_req = 1'b1;
        push(8'h02); push(8'h01); push(8'h02);
        step(5);
        chk("t3_ack",      128'(freeze_ack), 128'(1));
        chk("t3_held",     128'(src.size()), 128'(2));
        chk("t3_no_pop",   128'(ob_fifo_rd), 128'(0));
        freeze_req = 1'b0;
        drain(20);
        step(2);
        chk("t3_ack_off", 128'(freeze_ack), 128'(0));
        chk("t3_frames",  128'(frame_cnt),  128'(4));
        chk("t3_beats",   128'(beat_cnt),   128'(13));

        // 4: framing errors (missing SOT, SOT inside frame)
        seen_no  = 0;
        seen_sif = 0;
        push(8'h00); push(8'h01); push(8'h02);
        drain(20);
        step(2);
        chk("t4_no_sot_pulses", 128'(seen_no),   128'(ERR_EN));
        chk("t4_sif_pulses",    128'(seen_sif),  128'(ERR_EN));
        chk("t4_frames",        128'(frame_cnt), 128'(5));
        chk("t4_beats",         128'(beat_cnt),  128'(16));

        // 5: reset with a full buffer mid-frame
        ready = 1'b0;
        push(8'h01); push(8'h00); push(8'h00);
        step(4);
        chk("t5_pre_vld", 128'(osf_ob_out.tvalid), 128'(1));
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_async_vld",  128'(osf_ob_out.tvalid), 128'(0));
        chk("t5_async_beat", 128'(beat_cnt),          128'(0));
        chk("t5_async_frm",  128'(frame_cnt),         128'(0));
        step(2);
        rst_n = 1'b1;
        ready = 1'b1;
        step(1);
        push(8'h01); push(8'h02);
        drain(20);
        step(2);
        chk("t5_frames", 128'(frame_cnt), 128'(1));
        chk("t5_beats",  128'(beat_cnt),  128'(2));

        // 6: frame counter wrap
        force dut.frame_cnt = 32'hFFFF_FFFF;
        m_frames = 32'hFFFF_FFFF;
        step(2);
        release dut.frame_cnt;
        step(1);
        chk("t6_preload", 128'(frame_cnt), 128'(32'hFFFF_FFFF));
        push(8'h03);
        drain(20);
        step(2);
        chk("t6_wrap",  128'(frame_cnt), 128'(0));
        chk("t6_beats", 128'(beat_cnt),  128'(3));

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
